// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate stimulus/response checker: FSM state
// encoding and expected-output truth tables for common 2-input gates.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit i is the expected output for inA=i[0], inB=i[1]
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/err_sat_counter.sv
// Saturating error counter: async active-low reset, synchronous clear that
// takes priority over increment, holds at all-ones instead of wrapping.
module err_sat_counter #(
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/gate_stim_checker.sv
// Clocked stimulus/response checker for a 2-input gate: sweeps all four input
// vectors N_PASSES times, compares against TRUTH, reports errors and pass.
// Optional first-failure capture is enabled by GATE_CHECK_FIRST_FAIL_EN.
module gate_stim_checker
    import gate_test_pkg::*;
#(
    parameter logic [3:0] TRUTH         = TT_AND,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         N_PASSES      = 1,
    parameter int         ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gate_out,
    output logic             inA,
    output logic             inB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_CHECK_FIRST_FAIL_EN
    ,
    output logic [1:0]       first_fail_idx,
    output logic             first_fail_valid
`endif
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PASSES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_stim_checker: SETTLE_CYCLES must be >= 1");
    end
    if (N_PASSES < 1) begin : g_bad_passes
        $error("gate_stim_checker: N_PASSES must be >= 1");
    end

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            err_clr, err_inc;
    logic            mismatch;

    assign mismatch = (gate_out != TRUTH[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            sc_q    <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sc_q    <= sc_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sc_d    = sc_q;
        pc_d    = pc_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_clr = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 2'd0;
                    sc_d    = '0;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_clr = 1'b1;
                end
            end
            SETTLE: begin
                sc_d = sc_q + 1'b1;
                if (sc_q == SC_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_inc = mismatch;
                sc_d    = '0;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = SETTLE;
                end else if (pc_q != PC_LAST) begin
                    idx_d   = 2'd0;
                    pc_d    = pc_q + 1'b1;
                    state_d = SETTLE;
                end else begin
                    // Final sample decides pass together with the count so far
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_count == '0) && !mismatch;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    err_sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_clr),
        .inc   (err_inc),
        .count (err_count)
    );

`ifdef GATE_CHECK_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_idx   <= 2'd0;
            first_fail_valid <= 1'b0;
        end else if (err_clr) begin
            first_fail_idx   <= 2'd0;
            first_fail_valid <= 1'b0;
        end else if (err_inc && !first_fail_valid) begin
            first_fail_idx   <= idx_q;
            first_fail_valid <= 1'b1;
        end
    end
`endif

    assign inA  = idx_q[0];
    assign inB  = idx_q[1];
    assign busy = (state_q == SETTLE) || (state_q == CHECK);
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Randomized bench for gate_stim_checker: two configurations run side by side
// against an emulated gate whose truth table is chosen per run.
module tb_gate_stim_checker;
    import gate_test_pkg::*;

    localparam logic [3:0] REF_TT = TT_AND;
    localparam int S0 = 1, N0 = 1, W0 = 4;
    localparam int S1 = 2, N1 = 3, W1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] gate_tbl = TT_AND;

    logic a0, b0, busy0, done0, pass0, go0;
    logic a1, b1, busy1, done1, pass1, go1;
    logic [W0-1:0] err0;
    logic [W1-1:0] err1;
`ifdef GATE_CHECK_FIRST_FAIL_EN
    logic [1:0] ffi0, ffi1;
    logic ffv0, ffv1;
`endif

    // Emulated gate under test
    assign go0 = gate_tbl[{b0, a0}];
    assign go1 = gate_tbl[{b1, a1}];

    gate_stim_checker #(.TRUTH(REF_TT), .SETTLE_CYCLES(S0), .N_PASSES(N0), .ERR_W(W0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_out(go0),
        .inA(a0), .inB(b0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef GATE_CHECK_FIRST_FAIL_EN
        , .first_fail_idx(ffi0), .first_fail_valid(ffv0)
`endif
    );

    gate_stim_checker #(.TRUTH(REF_TT), .SETTLE_CYCLES(S1), .N_PASSES(N1), .ERR_W(W1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_out(go1),
        .inA(a1), .inB(b1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef GATE_CHECK_FIRST_FAIL_EN
        , .first_fail_idx(ffi1), .first_fail_valid(ffv1)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: run length, saturated error total, first failing vector
    function automatic int run_len(input int s, input int n);
        return 4 * n * (s + 1) + 1;
    endfunction

    function automatic int exp_err(input logic [3:0] tbl, input int n, input int w);
        int d = 0;
        int top = (1 << w) - 1;
        for (int i = 0; i < 4; i++) d += ((tbl[i] != REF_TT[i]) ? 1 : 0);
        d = d * n;
        return (d > top) ? top : d;
    endfunction

    function automatic int first_idx(input logic [3:0] tbl);
        for (int i = 0; i < 4; i++) if (tbl[i] != REF_TT[i]) return i;
        return 0;
    endfunction

    task automatic check_slot(input string tag, input int k, input int len, input int s,
                              input int n, input int w, input logic [3:0] tbl,
                              input logic bsy, input logic dn, input logic ps,
                              input logic a, input logic b, input logic [31:0] err);
        int e;
        if (k < len) begin
            expect_eq({tag, ".busy"}, bsy, 1);
            expect_eq({tag, ".done"}, dn, 0);
            expect_eq({tag, ".pass"}, ps, 0);
            expect_eq({tag, ".vec"}, {b, a}, ((k - 1) / (s + 1)) % 4);
            if (k == 1) expect_eq({tag, ".err_clr"}, err, 0);
        end else begin
            e = exp_err(tbl, n, w);
            expect_eq({tag, ".busy_end"}, bsy, 0);
            expect_eq({tag, ".done_end"}, dn, 1);
            expect_eq({tag, ".vec_end"}, {b, a}, 3);
            expect_eq({tag, ".err_end"}, err, e);
            expect_eq({tag, ".pass_end"}, ps, (e == 0) ? 1 : 0);
        end
    endtask

    task automatic run(input logic [3:0] tbl, input bit pulses);
        int l0 = run_len(S0, N0);
        int l1 = run_len(S1, N1);
        gate_tbl = tbl;
        start = 1'b1;
        for (int k = 1; k <= l1; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check_slot("u0", k, l0, S0, N0, W0, tbl, busy0, done0, pass0, a0, b0, 32'(err0));
            check_slot("u1", k, l1, S1, N1, W1, tbl, busy1, done1, pass1, a1, b1, 32'(err1));
`ifdef GATE_CHECK_FIRST_FAIL_EN
            if (k == 1) begin
                expect_eq("u0.ffv_clr", ffv0, 0);
                expect_eq("u1.ffv_clr", ffv1, 0);
            end
`endif
            // Stray start pulses land only while both instances are busy
            if (pulses && k <= 7) start = ($urandom_range(0, 2) == 0);
        end
`ifdef GATE_CHECK_FIRST_FAIL_EN
        expect_eq("u0.ffv", ffv0, (tbl != REF_TT) ? 1 : 0);
        expect_eq("u1.ffv", ffv1, (tbl != REF_TT) ? 1 : 0);
        if (tbl != REF_TT) begin
            expect_eq("u0.ffi", ffi0, first_idx(tbl));
            expect_eq("u1.ffi", ffi1, first_idx(tbl));
        end
`endif
    endtask

    task automatic check_idle(input string tag);
        expect_eq({tag, ".busy0"}, busy0, 0);
        expect_eq({tag, ".done0"}, done0, 0);
        expect_eq({tag, ".pass0"}, pass0, 0);
        expect_eq({tag, ".err0"}, err0, 0);
        expect_eq({tag, ".vec0"}, {b0, a0}, 0);
        expect_eq({tag, ".busy1"}, busy1, 0);
        expect_eq({tag, ".done1"}, done1, 0);
        expect_eq({tag, ".err1"}, err1, 0);
        expect_eq({tag, ".vec1"}, {b1, a1}, 0);
`ifdef GATE_CHECK_FIRST_FAIL_EN
        expect_eq({tag, ".ffv0"}, ffv0, 0);
        expect_eq({tag, ".ffv1"}, ffv1, 0);
`endif
    endtask

    task automatic reset_mid_run(input int depth);
        gate_tbl = 4'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (depth) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("idle_wait");

        run(TT_AND, 1'b0);
        run(4'b0000, 1'b0);
        run(TT_NAND, 1'b1);
        run(TT_AND, 1'b1);
        reset_mid_run(4);
        run(TT_OR, 1'b0);
        reset_mid_run(20);
        for (int r = 0; r < 8; r++) run(4'($urandom), 1'b1);
        run(TT_AND, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
Self-running stimulus and response checker that sits directly upstream and downstream of a 2-input gate DUT (and_gate, or_gate, ...). It drives inA/inB through all four input combinations and samples the gate's output after a settle interval. It compares each sample against a parameterised truth table and reports an error count and a pass flag. It replaces hand-written #delay stimulus with a clocked, synthesizable checker usable on-board.

Parameters:
TRUTH, 4'b1000, expected gate output per vector index i (bit i); vector i drives inA=i[0], inB=i[1]; default = AND
SETTLE_CYCLES, 1, cycles each vector is held before sampling; must be >=1, 0 is an elaboration error
N_PASSES, 1, number of full 4-vector sweeps per run; must be >=1
ERR_W, 4, width of err_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE or DONE
gate_out  input  1  output of the DUT gate
inA  output  1  DUT input A, registered
inB  output  1  DUT input B, registered
busy  output  1  high while a run is in progress
done  output  1  high in DONE; err_count and pass are valid
pass  output  1  done && err_count==0
err_count  output  ERR_W  mismatches in the current or last run, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE, inA=0, inB=0, busy=0, done=0, pass=0, err_count=0, vector index=0, pass counter=0, settle counter=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 -> SETTLE next cycle. On that edge: idx=0, inA/inB=0/0, err_count=0, pass counter=0, settle counter=0.
- SETTLE: hold inA/inB. Increment settle counter each cycle. After SETTLE_CYCLES cycles -> CHECK.
- CHECK (1 cycle): on the edge leaving CHECK, compare gate_out with TRUTH[idx]. On mismatch, err_count += 1, saturating at 2^ERR_W-1.
  - If idx<3: idx+=1, drive the new inA/inB on the same edge, clear settle counter -> SETTLE.
  - If idx==3 and pass counter<N_PASSES-1: idx=0, pass counter+=1 -> SETTLE.
  - Otherwise -> DONE.
- Latency: one vector takes SETTLE_CYCLES+1 cycles. start-to-done = 4*N_PASSES*(SETTLE_CYCLES+1)+1 cycles.
- busy=1 in SETTLE and CHECK only. done=1 only in DONE. pass is registered, valid only while done=1, otherwise 0.
- DONE: outputs held and inA/inB hold the last vector until start=1, which restarts exactly as from IDLE (err_count cleared).
- start while busy: ignored, with no effect on the run.
- gate_out is sampled only in CHECK; its value during SETTLE is don't-care.
- Reset asserted mid-run: abort immediately to reset values. No partial result is retained.

Optional Feature:
Macro GATE_CHECK_FIRST_FAIL_EN.
- Defined: adds output first_fail_idx [1:0] and output first_fail_valid [1]. On the first mismatch of a run, the checker latches idx and sets valid. Both clear on reset and on start. Later mismatches do not overwrite them.
- Undefined: neither port exists. Behaviour is otherwise identical.

Decomposition:
- Shared package gate_test_pkg:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3)
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001
- One sub-module is natural: err_sat_counter, a parameterised-width saturating incrementer with sync clear, used for err_count.

Test Plan:
- TRUTH=TT_AND, SETTLE=1, correct and_gate DUT, pulse start -> busy for 8 cycles, then done=1, pass=1, err_count=0. inA/inB sequence is 00,10,01,11.
- TRUTH=TT_AND, DUT stuck-at-0 -> err_count=1, pass=0. With GATE_CHECK_FIRST_FAIL_EN: first_fail_idx=3, first_fail_valid=1.
- TRUTH=TT_AND, DUT is NAND, N_PASSES=3, ERR_W=4 -> err_count=12. Repeat with ERR_W=3 -> err_count saturates at 7.
- Pulse start again in the middle of the run -> no effect; done still arrives at cycle 9 after the first start.
- Assert rst_n low in the middle of the run -> all outputs 0 immediately (asynchronously), before the next clk edge. After release, state is IDLE until start.
- After a failing run in DONE, swap in a correct DUT and pulse start -> err_count clears to 0, and the new run ends with pass=1.
